// File: rtl/expr_pkg.sv
// Shared constants and FSM state type for the expression character stream.
package expr_pkg;

  localparam logic [7:0] CH_0    = 8'h30;
  localparam logic [7:0] CH_PLUS = 8'h2B;
  localparam logic [7:0] CH_MUL  = 8'h2A;
  localparam logic [7:0] CH_NUL  = 8'h00;

  localparam logic OP_ADD = 1'b0;
  localparam logic OP_MUL = 1'b1;

  typedef enum logic [2:0] {
    IDLE,
    DIG,
    OP,
    NUL,
    FIN
  } state_t;

endpackage

// File: rtl/expr_char_enc.sv
// Maps a digit value or an operator code onto its ASCII character.
module expr_char_enc
  import expr_pkg::*;
(
  input  logic       is_op,
  input  logic [3:0] digit,
  input  logic       op,
  output logic [7:0] ch
);

  always_comb begin
    ch = CH_0 + {4'h0, digit};
    if (is_op) ch = (op == OP_MUL) ? CH_MUL : CH_PLUS;
  end

endmodule

// File: rtl/expr_gen.sv
// Serialises a latched digit/operator list into ASCII bytes over valid/ready.
// Optional EXPR_GEN_TERM_EN appends a NUL terminator byte after the last digit.
module expr_gen
  import expr_pkg::*;
#(
  parameter int unsigned MAX_TERMS = 8
) (
  input  logic                   clk,
  input  logic                   clr,
  input  logic                   start,
  input  logic [3:0]             num_terms,
  input  logic [4*MAX_TERMS-1:0] digits,
  input  logic [MAX_TERMS-2:0]   ops,
  input  logic                   out_ready,
  output logic                   out_valid,
  output logic [7:0]             out_char,
  output logic                   out_last,
  output logic                   busy,
  output logic                   done,
  output logic                   err
);

  localparam int unsigned IW = $clog2(MAX_TERMS);
  localparam logic [IW-1:0] IDX_ONE = 1;

  state_t                 state, nxt;
  logic [IW-1:0]          idx_q;
  logic [3:0]             nt_q;
  logic [4*MAX_TERMS-1:0] dig_q;
  logic [MAX_TERMS-2:0]   ops_q;
  logic                   err_q;

  logic                   req_ok;
  logic                   accept;
  logic                   is_last;
  logic [MAX_TERMS-1:0]   ops_ext;
  logic [3:0]             dig_sel;
  logic                   op_sel;
  logic [7:0]             enc_char;

  always_comb begin
    req_ok = 1'b1;
    if (num_terms == 4'd0 || 32'(num_terms) > MAX_TERMS) req_ok = 1'b0;
    for (int unsigned i = 0; i < MAX_TERMS; i++) begin
      if (i < 32'(num_terms) && digits[4*i +: 4] > 4'd9) req_ok = 1'b0;
    end
  end

  assign accept  = (state == IDLE) && start && req_ok;
  assign is_last = (4'(idx_q) == nt_q - 4'd1);
  // Pad so the last-term index never selects past the operator list.
  assign ops_ext = {1'b0, ops_q};
  assign dig_sel = dig_q[4*32'(idx_q) +: 4];
  assign op_sel  = ops_ext[idx_q];

  expr_char_enc u_enc (
    .is_op (state == OP),
    .digit (dig_sel),
    .op    (op_sel),
    .ch    (enc_char)
  );

  always_ff @(posedge clk) begin
    if (clr) begin
      state <= IDLE;
      idx_q <= '0;
      nt_q  <= '0;
      dig_q <= '0;
      ops_q <= '0;
      err_q <= 1'b0;
    end else begin
      state <= nxt;
      err_q <= (state == IDLE) && start && !req_ok;
      if (accept) begin
        nt_q  <= num_terms;
        dig_q <= digits;
        ops_q <= ops;
        idx_q <= '0;
      end else if (state == OP && out_ready) begin
        idx_q <= idx_q + IDX_ONE;
      end
    end
  end

  always_comb begin
    nxt       = state;
    out_valid = 1'b0;
    out_char  = 8'h00;
    out_last  = 1'b0;
    busy      = 1'b0;
    done      = 1'b0;
    case (state)
      IDLE: if (accept) nxt = DIG;
      DIG: begin
        out_valid = 1'b1;
        busy      = 1'b1;
        out_char  = enc_char;
`ifdef EXPR_GEN_TERM_EN
        if (out_ready) nxt = is_last ? NUL : OP;
`else
        out_last  = is_last;
        if (out_ready) nxt = is_last ? FIN : OP;
`endif
      end
      OP: begin
        out_valid = 1'b1;
        busy      = 1'b1;
        out_char  = enc_char;
        if (out_ready) nxt = DIG;
      end
      NUL: begin
        out_valid = 1'b1;
        busy      = 1'b1;
        out_char  = CH_NUL;
        out_last  = 1'b1;
        if (out_ready) nxt = FIN;
      end
      FIN: begin
        done = 1'b1;
        nxt  = IDLE;
      end
      default: nxt = IDLE;
    endcase
  end

  assign err = err_q;

endmodule

// File: tb/tb_expr_gen.sv
// Randomized self-checking bench for expr_gen against a character-list model.
module tb_expr_gen;

  localparam int MT = 8;

  logic          clk = 1'b0;
  logic          clr;
  logic          start;
  logic [3:0]    num_terms;
  logic [4*MT-1:0] digits;
  logic [MT-2:0] ops;
  logic          out_ready;
  logic          out_valid;
  logic [7:0]    out_char;
  logic          out_last;
  logic          busy;
  logic          done;
  logic          err;

  int n_checks = 0;
  int n_fail   = 0;

  expr_gen #(.MAX_TERMS(MT)) dut (
    .clk       (clk),
    .clr       (clr),
    .start     (start),
    .num_terms (num_terms),
    .digits    (digits),
    .ops       (ops),
    .out_ready (out_ready),
    .out_valid (out_valid),
    .out_char  (out_char),
    .out_last  (out_last),
    .busy      (busy),
    .done      (done),
    .err       (err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  // Expected character list built directly from the expression's text form.
  task automatic build(input int n, input logic [4*MT-1:0] dv, input logic [MT-2:0] ov,
                       output logic [7:0] cq[$]);
    logic [3:0] d;
    cq = {};
    for (int i = 0; i < n; i++) begin
      d = dv[4*i +: 4];
      cq.push_back(8'h30 + {4'h0, d});
      if (i < n - 1) cq.push_back(ov[i] ? 8'h2A : 8'h2B);
    end
`ifdef EXPR_GEN_TERM_EN
    cq.push_back(8'h00);
`endif
  endtask

  // Streams one expression; abort_at >= 0 asserts clr while that character is offered.
  task automatic run_expr(input int n, input logic [4*MT-1:0] dv, input logic [MT-2:0] ov,
                          input int stall_pct, input bit disturb, input int abort_at);
    logic [7:0] cq[$];
    int  k, cyc;
    bit  rdy;
    build(n, dv, ov, cq);
    num_terms = 4'(n);
    digits    = dv;
    ops       = ov;
    start     = 1'b1;
    out_ready = 1'b1;
    tick();
    start = 1'b0;
    k = 0;
    cyc = 0;
    while (k < cq.size() && cyc < 300) begin
      chk("valid", 32'(out_valid), 1);
      chk("busy", 32'(busy), 1);
      chk("char", 32'(out_char), 32'(cq[k]));
      chk("last", 32'(out_last), (k == cq.size() - 1) ? 1 : 0);
      chk("done_mid", 32'(done), 0);
      chk("err_mid", 32'(err), 0);
      if (k == abort_at) begin
        clr = 1'b1;
        tick();
        clr = 1'b0;
        chk("abort_valid", 32'(out_valid), 0);
        chk("abort_busy", 32'(busy), 0);
        chk("abort_done", 32'(done), 0);
        tick();
        chk("abort_done2", 32'(done), 0);
        chk("abort_valid2", 32'(out_valid), 0);
        return;
      end
      rdy = ($urandom_range(99) >= 32'(stall_pct));
      out_ready = rdy;
      if (disturb) begin
        start     = 1'($urandom);
        digits    = {$urandom};
        ops       = 7'($urandom);
        num_terms = 4'($urandom);
      end
      tick();
      if (rdy) k++;
      cyc++;
    end
    if (cyc >= 300) chk("timeout", 0, 1);
    chk("done", 32'(done), 1);
    chk("fin_valid", 32'(out_valid), 0);
    chk("fin_busy", 32'(busy), 0);
    chk("fin_err", 32'(err), 0);
    start = 1'b0;
    out_ready = 1'b1;
    tick();
    chk("done_once", 32'(done), 0);
    chk("idle_valid", 32'(out_valid), 0);
    chk("idle_err", 32'(err), 0);
  endtask

  task automatic reject(input string tag, input int n, input logic [4*MT-1:0] dv);
    num_terms = 4'(n);
    digits    = dv;
    ops       = '0;
    start     = 1'b1;
    tick();
    start = 1'b0;
    chk({tag, "_err"}, 32'(err), 1);
    chk({tag, "_busy"}, 32'(busy), 0);
    chk({tag, "_valid"}, 32'(out_valid), 0);
    tick();
    chk({tag, "_err_off"}, 32'(err), 0);
    chk({tag, "_valid2"}, 32'(out_valid), 0);
  endtask

  initial begin
    logic [4*MT-1:0] dv;
    int n;
    clr = 1'b1; start = 1'b0; num_terms = '0; digits = '0; ops = '0; out_ready = 1'b0;
    tick();
    tick();
    chk("rst_valid", 32'(out_valid), 0);
    chk("rst_char", 32'(out_char), 0);
    chk("rst_last", 32'(out_last), 0);
    chk("rst_busy", 32'(busy), 0);
    chk("rst_done", 32'(done), 0);
    chk("rst_err", 32'(err), 0);
    clr = 1'b0;
    tick();

    run_expr(4, 32'h4321, 7'b000, 0, 1'b0, -1);
    run_expr(3, 32'h709, 7'b001, 30, 1'b0, -1);
    run_expr(1, 32'h5, 7'h7F, 0, 1'b0, -1);
    run_expr(8, 32'h9876_5432, 7'h55, 20, 1'b0, -1);
    run_expr(2, 32'hA21, 7'b110, 0, 1'b0, -1);

    reject("n0", 0, 32'h1);
    reject("n9", 9, 32'h1111_1111);
    reject("digA", 3, 32'h0A3);
    reject("digF", 8, 32'hF000_0000);

    run_expr(3, 32'h321, 7'b000, 0, 1'b0, 2);
    run_expr(3, 32'h321, 7'b000, 0, 1'b0, -1);

    run_expr(5, 32'h8_1234, 7'b1010, 25, 1'b1, -1);

    for (int t = 0; t < 25; t++) begin
      n = $urandom_range(MT, 1);
      for (int i = 0; i < MT; i++) dv[4*i +: 4] = 4'($urandom_range(9));
      run_expr(n, dv, 7'($urandom), $urandom_range(50), 1'($urandom), -1);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
